// File: rtl/simon_sequencer.sv
// simon_sequencer
// Game-flow controller for the Simon datapath. A start pulse captures a
// 30-bit random word as five 6-bit symbols. The block plays a growing prefix
// of those symbols to the display and then checks the player's guesses one
// symbol at a time until the game ends in WIN or LOSE.
//
// Optional feature: define SIMON_TIMEOUT_EN to enable a guess timeout in WAIT.
// After TIMEOUT_CYCLES WAIT cycles without a guess, the game is lost.
// When the macro is undefined, WAIT lasts until a guess arrives.
module simon_sequencer #(
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [29:0] rand_num,
  input  logic        guess_valid,
  input  logic [5:0]  guess,
  output logic        display_valid,
  output logic [5:0]  display_num,
  output logic        busy,
  output logic [2:0]  level,
  output logic        win,
  output logic        lose
);

  // Game states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SHOW = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WIN  = 3'd3;
  localparam logic [2:0] ST_LOSE = 3'd4;

  localparam logic [2:0] MAX_LEVEL = 3'd5;

  // The phase counters count down to zero, so they load with length-1.
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  logic [2:0]  state_reg, state_next;
  logic [2:0]  level_reg, level_next;
  logic [2:0]  idx_reg, idx_next;
  logic        in_gap_reg, in_gap_next;
  logic [15:0] phase_cnt_reg, phase_cnt_next;
  logic        display_valid_reg, display_valid_next;
  logic [5:0]  display_num_reg, display_num_next;
  logic        busy_reg, win_reg, lose_reg;

  // The five captured symbols. Entry k holds rand_num[6k+5:6k].
  logic [5:0]  sym_reg [0:4];
  logic        load_syms;

  logic [5:0]  cur_sym;
  logic [5:0]  next_sym;
  logic [2:0]  idx_plus;
  logic        last_idx;

`ifdef SIMON_TIMEOUT_EN
  // The timeout counter counts up. Reaching TIMEOUT_LAST on a quiet WAIT
  // cycle means that the next edge is the TIMEOUT_CYCLES-th one.
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_cnt_reg, wait_cnt_next;
`endif

  assign idx_plus = idx_reg + 3'd1;
  assign cur_sym  = sym_reg[idx_reg];
  assign next_sym = sym_reg[idx_plus];
  assign last_idx = (idx_reg == (level_reg - 3'd1));

  // Symbol store: all five symbols are captured together on an accepted start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < 5; k++) begin
        sym_reg[k] <= '0;
      end
    end else if (load_syms) begin
      for (int k = 0; k < 5; k++) begin
        sym_reg[k] <= rand_num[6*k +: 6];
      end
    end
  end

  // Next-state logic for the game FSM, the playback phases and the display.
  always_comb begin
    state_next         = state_reg;
    level_next         = level_reg;
    idx_next           = idx_reg;
    in_gap_next        = in_gap_reg;
    phase_cnt_next     = phase_cnt_reg;
    display_valid_next = display_valid_reg;
    display_num_next   = display_num_reg;
    load_syms          = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    // The counter reloads in every case except a quiet WAIT cycle.
    wait_cnt_next      = '0;
`endif

    case (state_reg)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          // A new game shows symbol 0 in the very next cycle.
          load_syms          = 1'b1;
          state_next         = ST_SHOW;
          level_next         = 3'd1;
          idx_next           = 3'd0;
          in_gap_next        = 1'b0;
          phase_cnt_next     = HOLD_LOAD;
          display_valid_next = 1'b1;
          display_num_next   = rand_num[5:0];
        end
      end

      ST_SHOW: begin
        if (!in_gap_reg) begin
          if (phase_cnt_reg == 16'd0) begin
            // The hold phase is over, so blank the display for the gap.
            in_gap_next        = 1'b1;
            phase_cnt_next     = GAP_LOAD;
            display_valid_next = 1'b0;
            display_num_next   = 6'd0;
          end else begin
            phase_cnt_next = phase_cnt_reg - 16'd1;
          end
        end else begin
          if (phase_cnt_reg == 16'd0) begin
            if (last_idx) begin
              // The last gap of this pass is over, so collect guesses from symbol 0.
              state_next = ST_WAIT;
              idx_next   = 3'd0;
            end else begin
              idx_next           = idx_plus;
              in_gap_next        = 1'b0;
              phase_cnt_next     = HOLD_LOAD;
              display_valid_next = 1'b1;
              display_num_next   = next_sym;
            end
          end else begin
            phase_cnt_next = phase_cnt_reg - 16'd1;
          end
        end
      end

      ST_WAIT: begin
        if (guess_valid) begin
          if (guess != cur_sym) begin
            state_next = ST_LOSE;
          end else if (!last_idx) begin
            idx_next = idx_plus;
          end else if (level_reg != MAX_LEVEL) begin
            // The whole prefix matched, so replay it one symbol longer.
            state_next         = ST_SHOW;
            level_next         = level_reg + 3'd1;
            idx_next           = 3'd0;
            in_gap_next        = 1'b0;
            phase_cnt_next     = HOLD_LOAD;
            display_valid_next = 1'b1;
            display_num_next   = sym_reg[0];
          end else begin
            state_next = ST_WIN;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else begin
          if (wait_cnt_reg == TIMEOUT_LAST) begin
            state_next = ST_LOSE;
          end else begin
            wait_cnt_next = wait_cnt_reg + 32'd1;
          end
        end
`endif
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. The status flags are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg         <= ST_IDLE;
      level_reg         <= 3'd0;
      idx_reg           <= 3'd0;
      in_gap_reg        <= 1'b0;
      phase_cnt_reg     <= 16'd0;
      display_valid_reg <= 1'b0;
      display_num_reg   <= 6'd0;
      busy_reg          <= 1'b0;
      win_reg           <= 1'b0;
      lose_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      level_reg         <= level_next;
      idx_reg           <= idx_next;
      in_gap_reg        <= in_gap_next;
      phase_cnt_reg     <= phase_cnt_next;
      display_valid_reg <= display_valid_next;
      display_num_reg   <= display_num_next;
      busy_reg          <= (state_next == ST_SHOW) || (state_next == ST_WAIT);
      win_reg           <= (state_next == ST_WIN);
      lose_reg          <= (state_next == ST_LOSE);
    end
  end

`ifdef SIMON_TIMEOUT_EN
  // WAIT timeout counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`endif

  assign display_valid = display_valid_reg;
  assign display_num   = display_num_reg;
  assign busy          = busy_reg;
  assign level         = level_reg;
  assign win           = win_reg;
  assign lose          = lose_reg;

endmodule
